// File: rtl/hps_fpga_pio_pkg.sv
// Shared types for the HPS/FPGA PIO poller: FSM state encoding and counter widths.
package hps_fpga_pio_pkg;

    localparam int INTERVAL_W = 16;
    localparam int LAT_W      = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_LAT     = 2'd2,
        ST_CAPTURE = 2'd3
    } poll_state_e;

    typedef logic [INTERVAL_W-1:0] interval_cnt_t;
    typedef logic [LAT_W-1:0]      lat_cnt_t;

    // Counters run from N-1 down to 0, so a count of N cycles reloads with N-1.
    function automatic interval_cnt_t interval_reload(input int unsigned cycles);
        return interval_cnt_t'(cycles - 1);
    endfunction

    function automatic lat_cnt_t latency_reload(input int unsigned cycles);
        return lat_cnt_t'(cycles - 1);
    endfunction

endpackage

// File: rtl/hps_fpga_edge_detect.sv
// Registers the polled bit on each sample strobe and derives one-cycle rise/fall
// pulses plus a sticky change flag; the first sample after reset never counts as a change.
module hps_fpga_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic sample_i,
    input  logic bit_i,
    input  logic clear_i,
    output logic status_o,
    output logic valid_o,
    output logic rise_o,
    output logic fall_o,
    output logic sticky_o
);

    logic status_q, status_d;
    logic valid_q, valid_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;
    logic sticky_q, sticky_d;
    logic change;

    assign change = sample_i && valid_q && (bit_i != status_q);

    always_comb begin
        status_d = status_q;
        valid_d  = valid_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        sticky_d = sticky_q;
        if (sample_i) begin
            status_d = bit_i;
            valid_d  = 1'b1;
        end
        // A change in the same cycle as a clear keeps the flag set.
        if (change) begin
            rise_d   = bit_i;
            fall_d   = !bit_i;
            sticky_d = 1'b1;
        end else if (clear_i) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            status_q <= 1'b0;
            valid_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            status_q <= status_d;
            valid_q  <= valid_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            sticky_q <= sticky_d;
        end
    end

    assign status_o = status_q;
    assign valid_o  = valid_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign sticky_o = sticky_q;

endmodule

// File: rtl/hps_fpga_pio_poller.sv
// Periodic Avalon-MM poller: reads POLL_ADDR every POLL_INTERVAL idle cycles and reports
// readdata[0] as a status bit with change pulses, a sticky change flag and a poll counter.
module hps_fpga_pio_poller
    import hps_fpga_pio_pkg::*;
#(
    parameter int unsigned POLL_INTERVAL = 1000,
    parameter int unsigned READ_LATENCY  = 1,
    parameter logic [1:0]  POLL_ADDR     = 2'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [1:0]  avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        status,
    output logic        status_valid,
    output logic        rise_pulse,
    output logic        fall_pulse,
    output logic        event_sticky,
    input  logic        event_clear,
    output logic [15:0] poll_count,
    output poll_state_e dbg_state_o
);

    localparam interval_cnt_t INTERVAL_RELOAD = interval_reload(POLL_INTERVAL);
    localparam lat_cnt_t      LATENCY_RELOAD  = latency_reload(READ_LATENCY);

    poll_state_e   state_q, state_d;
    interval_cnt_t interval_cnt_q, interval_cnt_d;
    lat_cnt_t      lat_cnt_q, lat_cnt_d;
    logic [15:0]   poll_count_q, poll_count_d;
    logic          sample_stb;
    logic          unused_readdata;

    // Only bit 0 of the polled word carries information.
    assign unused_readdata = ^avm_readdata[31:1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            interval_cnt_q <= '0;
            lat_cnt_q      <= '0;
            poll_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            interval_cnt_q <= interval_cnt_d;
            lat_cnt_q      <= lat_cnt_d;
            poll_count_q   <= poll_count_d;
        end
    end

    // LAT spans READ_LATENCY cycles after acceptance; its last cycle is the one in which
    // readdata is valid, so the sample strobe fires there and CAPTURE is the cycle the
    // registered results first become visible.
    always_comb begin
        state_d        = state_q;
        interval_cnt_d = interval_cnt_q;
        lat_cnt_d      = lat_cnt_q;
        sample_stb     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!enable) begin
                    interval_cnt_d = INTERVAL_RELOAD;
                end else if (interval_cnt_q == '0) begin
                    state_d = ST_REQ;
                end else begin
                    interval_cnt_d = interval_cnt_q - 1'b1;
                end
            end
            ST_REQ: begin
                if (!avm_waitrequest) begin
                    state_d   = ST_LAT;
                    lat_cnt_d = LATENCY_RELOAD;
                end
            end
            ST_LAT: begin
                if (lat_cnt_q == '0) begin
                    sample_stb = 1'b1;
                    state_d    = ST_CAPTURE;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            ST_CAPTURE: begin
                state_d        = ST_IDLE;
                interval_cnt_d = INTERVAL_RELOAD;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign poll_count_d = sample_stb ? poll_count_q + 16'd1 : poll_count_q;

    assign avm_read    = (state_q == ST_REQ);
    assign avm_address = avm_read ? POLL_ADDR : 2'd0;
    assign poll_count  = poll_count_q;
    assign dbg_state_o = state_q;

    hps_fpga_edge_detect u_edge_detect (
        .clk      (clk),
        .reset    (reset),
        .sample_i (sample_stb),
        .bit_i    (avm_readdata[0]),
        .clear_i  (event_clear),
        .status_o (status),
        .valid_o  (status_valid),
        .rise_o   (rise_pulse),
        .fall_o   (fall_pulse),
        .sticky_o (event_sticky)
    );

endmodule

// File: tb/tb_hps_fpga_pio_poller.sv
// Bench for hps_fpga_pio_poller: table-driven poll sequence, hand-written corner cases
// and a randomized run against a cycle-arithmetic reference model.
module tb_hps_fpga_pio_poller;
    import hps_fpga_pio_pkg::*;

    localparam int         A_INT  = 4;
    localparam int         A_LAT  = 1;
    localparam logic [1:0] A_ADDR = 2'd2;
    localparam int         B_INT  = 2;
    localparam int         B_LAT  = 3;
    localparam logic [1:0] B_ADDR = 2'd1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT A (interval 4, latency 1) ----------------
    logic        reset_a, enable_a, wait_a, clear_a;
    logic [31:0] rdata_a;
    logic [1:0]  addr_a;
    logic        read_a, status_a, valid_a, rise_a, fall_a, sticky_a;
    logic [15:0] count_a;
    poll_state_e dbg_a;

    hps_fpga_pio_poller #(
        .POLL_INTERVAL (A_INT),
        .READ_LATENCY  (A_LAT),
        .POLL_ADDR     (A_ADDR)
    ) dut_a (
        .clk             (clk),
        .reset           (reset_a),
        .enable          (enable_a),
        .avm_address     (addr_a),
        .avm_read        (read_a),
        .avm_waitrequest (wait_a),
        .avm_readdata    (rdata_a),
        .status          (status_a),
        .status_valid    (valid_a),
        .rise_pulse      (rise_a),
        .fall_pulse      (fall_a),
        .event_sticky    (sticky_a),
        .event_clear     (clear_a),
        .poll_count      (count_a),
        .dbg_state_o     (dbg_a)
    );

    // ---------------- DUT B (interval 2, latency 3) ----------------
    logic        reset_b, enable_b, wait_b, clear_b;
    logic [31:0] rdata_b;
    logic [1:0]  addr_b;
    logic        read_b, status_b, valid_b, rise_b, fall_b, sticky_b;
    logic [15:0] count_b;
    poll_state_e dbg_b;

    hps_fpga_pio_poller #(
        .POLL_INTERVAL (B_INT),
        .READ_LATENCY  (B_LAT),
        .POLL_ADDR     (B_ADDR)
    ) dut_b (
        .clk             (clk),
        .reset           (reset_b),
        .enable          (enable_b),
        .avm_address     (addr_b),
        .avm_read        (read_b),
        .avm_waitrequest (wait_b),
        .avm_readdata    (rdata_b),
        .status          (status_b),
        .status_valid    (valid_b),
        .rise_pulse      (rise_b),
        .fall_pulse      (fall_b),
        .event_sticky    (sticky_b),
        .event_clear     (clear_b),
        .poll_count      (count_b),
        .dbg_state_o     (dbg_b)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [16:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    typedef struct packed {
        logic bitv;
        logic clr;
        logic st;
        logic rise;
        logic fall;
        logic sticky;
    } vec_t;

    vec_t vecs[7];

    // ---------------- driver tasks ----------------
    // Waits for a read on DUT A, optionally stalls it, accepts it and presents bitv only
    // in the sample cycle (acceptance + 1). Returns at the negedge of the visibility cycle.
    task automatic do_poll_a(input logic bitv, input logic clr, input int stall,
                             input logic drop_en, output int acc);
        int n;
        acc = -1;
        n = 0;
        while (read_a !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("a_read_start", 32'(read_a), 32'd1);
        if (read_a !== 1'b1) return;
        if (drop_en) enable_a = 1'b0;
        for (int s = 0; s < stall; s++) begin
            wait_a  = 1'b1;
            rdata_a = {31'($urandom), ~bitv};
            @(negedge clk);
            check("a_read_held", 32'(read_a), 32'd1);
            check("a_addr_held", 32'(addr_a), 32'(A_ADDR));
        end
        check("a_addr", 32'(addr_a), 32'(A_ADDR));
        wait_a  = 1'b0;
        acc     = cyc;
        rdata_a = {31'($urandom), ~bitv};
        @(negedge clk);
        check("a_single_read", 32'(read_a), 32'd0);
        rdata_a = {31'($urandom), bitv};
        clear_a = clr;
        wait_a  = 1'b1;
        @(negedge clk);
        check("a_no_reread", 32'(read_a), 32'd0);
        rdata_a = {31'($urandom), ~bitv};
        clear_a = 1'b0;
        wait_a  = 1'b0;
    endtask

    // ---------------- main test ----------------
    initial begin
        int          acc, prev_acc, n, reads_seen;
        logic [15:0] exp_cnt;
        int          next_req, cap_cyc, vis_cyc;
        logic        cap_pending, vis_pending, exp_rd, b, nxt_sticky;
        logic        m_status, m_valid, m_rise, m_fall, m_sticky;
        logic [15:0] m_count;
        logic [16:0] exp_item;

        //               bit   clr   st    rise  fall  sticky
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        reset_a = 1'b1; enable_a = 1'b0; wait_a = 1'b0; clear_a = 1'b0; rdata_a = '0;
        reset_b = 1'b1; enable_b = 1'b0; wait_b = 1'b0; clear_b = 1'b0; rdata_b = '0;
        repeat (3) @(negedge clk);

        // Reset state of both instances.
        check("rst_a_read", 32'(read_a), 32'd0);
        check("rst_a_addr", 32'(addr_a), 32'd0);
        check("rst_a_status", 32'(status_a), 32'd0);
        check("rst_a_valid", 32'(valid_a), 32'd0);
        check("rst_a_pulses", 32'({rise_a, fall_a}), 32'd0);
        check("rst_a_sticky", 32'(sticky_a), 32'd0);
        check("rst_a_count", 32'(count_a), 32'd0);
        check("rst_a_state", 32'(dbg_a), 32'(ST_IDLE));
        check("rst_b_valid", 32'(valid_b), 32'd0);
        check("rst_b_count", 32'(count_b), 32'd0);

        reset_a = 1'b0;
        reset_b = 1'b0;
        @(negedge clk);
        enable_a = 1'b1;

        // Table-driven poll sequence on DUT A.
        exp_cnt  = 16'd0;
        prev_acc = -1;
        for (int i = 0; i < 7; i++) begin
            do_poll_a(vecs[i].bitv, vecs[i].clr, 0, 1'b0, acc);
            exp_cnt++;
            check("tbl_status", 32'(status_a), 32'(vecs[i].st));
            check("tbl_valid", 32'(valid_a), 32'd1);
            check("tbl_rise", 32'(rise_a), 32'(vecs[i].rise));
            check("tbl_fall", 32'(fall_a), 32'(vecs[i].fall));
            check("tbl_sticky", 32'(event_sticky_a_w()), 32'(vecs[i].sticky));
            check("tbl_count", 32'(count_a), 32'(exp_cnt));
            // Interval 4 + request + one latency cycle + capture = 7-cycle poll period.
            if (i > 0) check("tbl_period", 32'(acc - prev_acc), 32'd7);
            prev_acc = acc;
            @(negedge clk);
            check("tbl_pulse_width", 32'({rise_a, fall_a}), 32'd0);
        end

        // Waitrequest stall of 3 cycles, then a 0->1 change.
        do_poll_a(1'b1, 1'b0, 3, 1'b0, acc);
        exp_cnt++;
        check("stall_status", 32'(status_a), 32'd1);
        check("stall_rise", 32'(rise_a), 32'd1);
        check("stall_count", 32'(count_a), 32'(exp_cnt));

        // Enable dropped while the request is stalled: the read still completes.
        do_poll_a(1'b0, 1'b0, 2, 1'b1, acc);
        exp_cnt++;
        check("endrop_status", 32'(status_a), 32'd0);
        check("endrop_fall", 32'(fall_a), 32'd1);
        check("endrop_count", 32'(count_a), 32'(exp_cnt));
        reads_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (read_a === 1'b1) reads_seen++;
        end
        check("endrop_no_more_reads", 32'(reads_seen), 32'd0);

        // Counter wrap: preload the poll counter just below the limit.
        force dut_a.poll_count_q = 16'hFFFF;
        @(negedge clk);
        release dut_a.poll_count_q;
        @(negedge clk);
        check("wrap_preload", 32'(count_a), 32'h0000FFFF);
        enable_a = 1'b1;
        do_poll_a(1'b1, 1'b0, 0, 1'b0, acc);
        check("wrap_count", 32'(count_a), 32'd0);
        check("wrap_status", 32'(status_a), 32'd1);
        enable_a = 1'b0;

        // DUT B: latency 3 sampling, then reset during LAT.
        @(negedge clk);
        enable_b = 1'b1;
        n = 0;
        while (read_b !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("b_read_start", 32'(read_b), 32'd1);
        check("b_addr", 32'(addr_b), 32'(B_ADDR));
        rdata_b = {31'($urandom), 1'b0};
        repeat (3) @(negedge clk);
        rdata_b = {31'($urandom), 1'b1};
        @(negedge clk);
        rdata_b = {31'($urandom), 1'b0};
        check("b_lat3_status", 32'(status_b), 32'd1);
        check("b_lat3_valid", 32'(valid_b), 32'd1);
        check("b_lat3_first_no_pulse", 32'({rise_b, fall_b}), 32'd0);
        check("b_lat3_count", 32'(count_b), 32'd1);

        n = 0;
        while (read_b !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("b_read_start2", 32'(read_b), 32'd1);
        rdata_b = {31'($urandom), 1'b0};
        @(negedge clk);
        reset_b = 1'b1;
        rdata_b = 32'hFFFF_FFFF;
        @(negedge clk);
        check("b_rst_read", 32'(read_b), 32'd0);
        check("b_rst_addr", 32'(addr_b), 32'd0);
        check("b_rst_status", 32'(status_b), 32'd0);
        check("b_rst_valid", 32'(valid_b), 32'd0);
        check("b_rst_pulses", 32'({rise_b, fall_b}), 32'd0);
        check("b_rst_sticky", 32'(sticky_b), 32'd0);
        check("b_rst_count", 32'(count_b), 32'd0);
        reset_b  = 1'b0;
        enable_b = 1'b0;
        repeat (5) @(negedge clk);
        check("b_stale_valid", 32'(valid_b), 32'd0);
        check("b_stale_status", 32'(status_b), 32'd0);
        check("b_stale_count", 32'(count_b), 32'd0);

        // Randomized run on DUT A against the reference model.
        reset_a = 1'b1; enable_a = 1'b0; clear_a = 1'b0; wait_a = 1'b0;
        repeat (2) @(negedge clk);
        reset_a = 1'b0;
        @(negedge clk);
        enable_a    = 1'b1;
        next_req    = cyc + A_INT;
        cap_pending = 1'b0; vis_pending = 1'b0; cap_cyc = 0; vis_cyc = 0;
        m_status = 1'b0; m_valid = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_sticky = 1'b0;
        m_count  = 16'd0;
        exp_q.delete();
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            exp_rd = (cyc >= next_req);
            check("r_read", 32'(read_a), 32'(exp_rd));
            if (exp_rd) check("r_addr", 32'(addr_a), 32'(A_ADDR));
            check("r_status", 32'(status_a), 32'(m_status));
            check("r_valid", 32'(valid_a), 32'(m_valid));
            check("r_rise", 32'(rise_a), 32'(m_rise));
            check("r_fall", 32'(fall_a), 32'(m_fall));
            check("r_sticky", 32'(sticky_a), 32'(m_sticky));
            check("r_count", 32'(count_a), 32'(m_count));
            if (vis_pending && cyc == vis_cyc) begin
                vis_pending = 1'b0;
                if (exp_q.size() == 0) begin
                    check("r_queue_nonempty", 32'd0, 32'd1);
                end else begin
                    exp_item = exp_q.pop_front();
                    check("r_poll_result", 32'({count_a, status_a}), 32'(exp_item));
                end
            end

            wait_a  = ($urandom_range(0, 2) == 0);
            rdata_a = $urandom;
            clear_a = ($urandom_range(0, 7) == 0);

            nxt_sticky = clear_a ? 1'b0 : m_sticky;
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (cap_pending && cyc == cap_cyc) begin
                b = rdata_a[0];
                if (m_valid && (b != m_status)) begin
                    m_rise     = b;
                    m_fall     = !b;
                    nxt_sticky = 1'b1;
                end
                m_status = b;
                m_valid  = 1'b1;
                m_count  = m_count + 16'd1;
                exp_q.push_back({m_count, b});
                cap_pending = 1'b0;
                vis_pending = 1'b1;
                vis_cyc     = cyc + 1;
            end
            m_sticky = nxt_sticky;
            if (exp_rd && !wait_a) begin
                cap_pending = 1'b1;
                cap_cyc     = cyc + A_LAT;
                next_req    = cyc + A_LAT + A_INT + 2;
            end
        end
        check("r_polls_seen", 32'(m_count > 16'd40), 32'd1);
        wait_a  = 1'b0;
        clear_a = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic logic event_sticky_a_w();
        return sticky_a;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
